// File: rtl/i2c_eeprom_responder.sv
// I2C target emulating a single 8-byte EEPROM page with a wrapping 3-bit byte pointer.
// Supports random/sequential reads, byte/page writes and repeated START; never drives SCL.
module i2c_eeprom_responder #(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter logic [63:0] INIT_PAGE = 64'h0000_0000_0000_0002
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       t_sda,
    output logic       o_wr_strobe,
    output logic [2:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_WORD_ADDR, S_WORD_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_scl_s, r_sda_s;
    logic        r_scl_d, r_sda_d;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_ptr, w_ptr_nxt;
    logic        r_rd, w_rd_nxt;
    logic        r_tsda, w_tsda_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_we;
    logic        r_wr_strobe;
    logic [2:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_mem [8];

    logic        w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
    logic [7:0]  w_byte;
    logic [2:0]  w_ptr_inc;

    assign w_scl     = r_scl_s[1];
    assign w_sda     = r_sda_s[1];
    assign w_rise    = w_scl & ~r_scl_d;
    assign w_fall    = ~w_scl & r_scl_d;
    assign w_start   = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop    = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_ptr_inc = r_ptr + 3'd1;

    assign o_sda       = 1'b0;
    assign t_sda       = r_tsda;
    assign o_busy      = r_busy;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ACK states use r_cnt as a phase: 0 = waiting to drive ACK, 1 = ACK driven.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_ptr_nxt   = r_ptr;
        w_rd_nxt    = r_rd;
        w_tsda_nxt  = r_tsda;
        w_busy_nxt  = r_busy;
        w_we        = 1'b0;
        if (w_start) begin
            w_state_nxt = S_DEV_ADDR;
            w_cnt_nxt   = 4'd0;
            w_tsda_nxt  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
            w_tsda_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_DEV_ADDR, S_WORD_ADDR, S_WR_DATA: if (w_rise) begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (r_cnt == 4'd7) begin
                        w_cnt_nxt = 4'd0;
                        if (r_state == S_DEV_ADDR) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                w_state_nxt = S_DEV_ACK;
                                w_busy_nxt  = 1'b1;
                                w_rd_nxt    = w_byte[0];
                                if (w_byte[0]) w_shift_nxt = r_mem[r_ptr];
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else if (r_state == S_WORD_ADDR) begin
                            w_ptr_nxt   = w_byte[2:0];
                            w_state_nxt = S_WORD_ACK;
                        end else begin
                            w_we        = 1'b1;
                            w_ptr_nxt   = w_ptr_inc;
                            w_state_nxt = S_WR_ACK;
                        end
                    end
                end
                S_DEV_ACK, S_WORD_ACK, S_WR_ACK: if (w_fall) begin
                    if (r_cnt == 4'd0) begin
                        w_tsda_nxt = 1'b0;
                        w_cnt_nxt  = 4'd1;
                    end else if (r_state == S_DEV_ACK && r_rd) begin
                        w_tsda_nxt  = r_shift[7];
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = S_RD_DATA;
                    end else begin
                        w_tsda_nxt  = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = (r_state == S_DEV_ACK) ? S_WORD_ADDR : S_WR_DATA;
                    end
                end
                S_RD_DATA: if (w_fall) begin
                    if (r_cnt == 4'd8) begin
                        w_tsda_nxt  = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_RD_ACK;
                    end else begin
                        w_tsda_nxt  = r_shift[7];
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end
                end
                // r_cnt = 1 marks a master ACK seen with the next byte already loaded.
                S_RD_ACK: begin
                    if (w_rise && r_cnt == 4'd0) begin
                        if (w_sda) begin
                            w_state_nxt = S_IDLE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_shift_nxt = r_mem[w_ptr_inc];
                            w_cnt_nxt   = 4'd1;
                        end
                    end else if (w_fall && r_cnt == 4'd1) begin
                        w_tsda_nxt  = r_shift[7];
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_state_nxt = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_s     <= 2'b11;
            r_sda_s     <= 2'b11;
            r_scl_d     <= 1'b1;
            r_sda_d     <= 1'b1;
            r_cnt       <= 4'd0;
            r_shift     <= 8'd0;
            r_ptr       <= 3'd0;
            r_rd        <= 1'b0;
            r_tsda      <= 1'b1;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 3'd0;
            r_wr_data   <= 8'd0;
            for (int n = 0; n < 8; n++) r_mem[n] <= INIT_PAGE[8*n +: 8];
        end else begin
            r_scl_s     <= {r_scl_s[0], i_scl};
            r_sda_s     <= {r_sda_s[0], i_sda};
            r_scl_d     <= w_scl;
            r_sda_d     <= w_sda;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rd        <= w_rd_nxt;
            r_tsda      <= w_tsda_nxt;
            r_busy      <= w_busy_nxt;
            r_wr_strobe <= w_we;
            if (w_we) begin
                r_mem[r_ptr] <= w_byte;
                r_wr_addr    <= r_ptr;
                r_wr_data    <= w_byte;
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_responder.sv
// Bench for i2c_eeprom_responder: bus-level master tasks driven against a transaction-level page model.
module tb_i2c_eeprom_responder;

    localparam logic [63:0] INIT = 64'h0000_0000_0000_0002;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda;
    logic       o_sda, t_sda, o_wr_strobe, o_busy;
    logic [2:0] o_wr_addr;
    logic [7:0] o_wr_data;
    wire        bus_sda = m_sda & (t_sda | o_sda);

    int          n_cmp = 0, n_mis = 0;
    int          n_drv = 0, n_busy = 0;
    logic [7:0]  mdl_mem [8];
    int          mdl_ptr;
    logic [10:0] stb_q [$];
    logic [7:0]  wbuf [16];

    always #25 clk = ~clk;

    i2c_eeprom_responder #(.DEV_ADDR(7'h50), .INIT_PAGE(INIT)) dut (
        .clk(clk), .reset(rst), .i_scl(m_scl), .i_sda(bus_sda),
        .o_sda(o_sda), .t_sda(t_sda), .o_wr_strobe(o_wr_strobe),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy)
    );

    always @(negedge clk) begin
        if (o_wr_strobe) stb_q.push_back({o_wr_addr, o_wr_data});
        if (!t_sda) n_drv++;
        if (o_busy) n_busy++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sbit(input logic b, output logic r);
        tick(3); m_sda = b; tick(3); m_scl = 1'b1; tick(3); r = bus_sda; tick(3); m_scl = 1'b0;
    endtask

    task automatic i2c_start();
        tick(3); m_sda = 1'b1; tick(3); m_scl = 1'b1; tick(3); m_sda = 1'b0; tick(3); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(3); m_sda = 1'b0; tick(3); m_scl = 1'b1; tick(3); m_sda = 1'b1; tick(3);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) sbit(d[i], r);
        sbit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            sbit(1'b1, r);
            d = {d[6:0], r};
        end
        sbit(nack, r);
    endtask

    task automatic model_reset();
        for (int n = 0; n < 8; n++) mdl_mem[n] = INIT[8*n +: 8];
        mdl_ptr = 0;
    endtask

    // Page write of n bytes from wbuf at word address w, then STOP; checks ACKs and strobes.
    task automatic do_write(input int w, input int n, input string tag);
        logic       ack;
        int         base;
        logic [10:0] exp_q [$];
        base = stb_q.size();
        i2c_start();
        wr_byte(8'hA0, ack); chk({tag, "_devack"}, ack, 0);
        wr_byte(8'(w), ack); chk({tag, "_wordack"}, ack, 0);
        mdl_ptr = w % 8;
        for (int i = 0; i < n; i++) begin
            wr_byte(wbuf[i], ack); chk({tag, "_dataack"}, ack, 0);
            exp_q.push_back({3'(mdl_ptr), wbuf[i]});
            mdl_mem[mdl_ptr] = wbuf[i];
            mdl_ptr = (mdl_ptr + 1) % 8;
        end
        i2c_stop();
        tick(4);
        chk({tag, "_nstrobe"}, stb_q.size() - base, n);
        for (int i = 0; i < n; i++)
            if (base + i < stb_q.size()) chk({tag, "_strobe"}, stb_q[base + i], exp_q[i]);
    endtask

    // Sequential read of n bytes; optionally sets the pointer first via a word write + Sr.
    task automatic do_read(input logic set_w, input int w, input int n, input string tag);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        if (set_w) begin
            wr_byte(8'hA0, ack); chk({tag, "_wdevack"}, ack, 0);
            wr_byte(8'(w), ack); chk({tag, "_wordack"}, ack, 0);
            mdl_ptr = w % 8;
            i2c_start();
        end
        wr_byte(8'hA1, ack); chk({tag, "_rdevack"}, ack, 0);
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, d);
            chk({tag, "_data"}, d, mdl_mem[mdl_ptr]);
            if (i < n - 1) mdl_ptr = (mdl_ptr + 1) % 8;
        end
        i2c_stop();
        tick(4);
        chk({tag, "_busy_off"}, o_busy, 0);
        chk({tag, "_released"}, t_sda, 1);
    endtask

    initial begin
        logic ack;
        int   base, drv_base, busy_base;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        model_reset();
        tick(3);
        chk("rst_tsda", t_sda, 1);
        chk("rst_osda", o_sda, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_strobe", o_wr_strobe, 0);
        chk("rst_addr", o_wr_addr, 0);
        chk("rst_data", o_wr_data, 0);
        rst = 1'b0;
        tick(5);

        // Default page read.
        busy_base = n_busy;
        do_read(1'b1, 0, 8, "t1");
        chk("t1_busy_seen", n_busy > busy_base, 1);

        // Wrong address: no ACK, no busy, and later bytes without START are ignored.
        drv_base = n_drv; busy_base = n_busy;
        i2c_start();
        wr_byte(8'hA2, ack); chk("t2_nack", ack, 1);
        wr_byte(8'hA0, ack); chk("t2_idle_ignores", ack, 1);
        i2c_stop();
        tick(4);
        chk("t2_never_drove", n_drv - drv_base, 0);
        chk("t2_never_busy", n_busy - busy_base, 0);

        // Page write with wrap, then read from 0.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(6, 3, "t3");
        do_read(1'b1, 0, 1, "t3r");

        // Read wrap from pointer 7 set in an earlier transaction.
        do_write(7, 0, "t4w");
        do_read(1'b0, 0, 2, "t4");

        // STOP mid-byte discards the partial write.
        base = stb_q.size();
        i2c_start();
        wr_byte(8'hA0, ack); chk("t5_devack", ack, 0);
        wr_byte(8'h01, ack); chk("t5_wordack", ack, 0);
        mdl_ptr = 1;
        for (int i = 0; i < 4; i++) sbit(1'($urandom_range(0, 1)), ack);
        i2c_stop();
        tick(4);
        chk("t5_nostrobe", stb_q.size() - base, 0);
        chk("t5_released", t_sda, 1);
        chk("t5_busy_off", o_busy, 0);
        do_read(1'b1, 0, 8, "t5r");

        // Reset while the responder drives a 0 data bit.
        i2c_start();
        wr_byte(8'hA0, ack); chk("t6_devack", ack, 0);
        wr_byte(8'h00, ack); chk("t6_wordack", ack, 0);
        i2c_start();
        wr_byte(8'hA1, ack); chk("t6_rdevack", ack, 0);
        tick(4);
        chk("t6_drive_low", t_sda, mdl_mem[0][7]);
        rst = 1'b1;
        #2;
        chk("t6_async_release", t_sda, 1);
        chk("t6_busy_off", o_busy, 0);
        tick(2);
        rst = 1'b0;
        model_reset();
        m_sda = 1'b1; tick(3); m_scl = 1'b1; tick(4);
        do_read(1'b0, 0, 8, "t6r");

        // Randomized writes and reads against the page model.
        for (int it = 0; it < 8; it++) begin
            int w, n;
            w = $urandom_range(0, 255);
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
            do_write(w, n, "rnd_wr");
            do_read(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(1, 9), "rnd_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
